// File: rtl/pic_pkg.sv
// pic_pkg: shared widths and rotation/level helpers for the PIC priority stage
package pic_pkg;
  localparam int PIC_NUM_IR = 8;
  localparam int PIC_LVL_W = 3;
  typedef logic [PIC_NUM_IR-1:0] ir_vec_t;
  typedef logic [PIC_LVL_W-1:0] lvl_t;
  function automatic ir_vec_t rotate_right(input ir_vec_t vec, input lvl_t amt);
    return ir_vec_t'({vec, vec} >> amt);
  endfunction
  function automatic ir_vec_t rotate_left(input ir_vec_t vec, input lvl_t amt);
    return ir_vec_t'(({vec, vec} << amt) >> PIC_NUM_IR);
  endfunction
  function automatic lvl_t onehot_to_level(input ir_vec_t vec);
    lvl_t lvl;
    lvl = '0;
    for (int i = 0; i < PIC_NUM_IR; i++) if (vec[i]) lvl = PIC_LVL_W'(i);
    return lvl;
  endfunction
  // Level of the highest-priority set bit given the current lowest-priority pointer; 0 if empty.
  function automatic lvl_t top_level(input ir_vec_t vec, input lvl_t lowest);
    lvl_t base;
    ir_vec_t r;
    base = lowest + lvl_t'(1);
    r = rotate_right(vec, base);
    return onehot_to_level(rotate_left(r & (~r + ir_vec_t'(1)), base));
  endfunction
endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: lowest-index-first one-hot pick on a pre-rotated vector
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [PIC_NUM_IR-1:0] vec,
  output logic [PIC_NUM_IR-1:0] pick
);
  assign pick = vec & (~vec + ir_vec_t'(1));
endmodule

// File: rtl/pic_priority_isr.sv
// pic_priority_isr: 8259 priority resolver with in-service register and rotating priority
module pic_priority_isr
  import pic_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIC_NUM_IR-1:0] irr,
  input  logic [PIC_NUM_IR-1:0] imr,
  input  logic                  special_mask_mode,
  input  logic                  special_fully_nested,
  input  logic                  auto_rotate,
  input  logic                  latch_in_service,
  input  logic                  freeze,
  input  logic [PIC_NUM_IR-1:0] end_of_interrupt,
  input  logic                  rotate_on_eoi,
  input  logic                  priority_rotate_set,
  input  logic [PIC_LVL_W-1:0]  priority_rotate_level,
  output logic [PIC_NUM_IR-1:0] interrupt,
  output logic [PIC_NUM_IR-1:0] in_service,
  output logic [PIC_LVL_W-1:0]  highest_in_service,
  output logic                  isr_active,
  output logic [PIC_LVL_W-1:0]  lowest_priority
);
  logic [PIC_NUM_IR-1:0] interrupt_q, interrupt_d, in_service_q, in_service_d;
  logic [PIC_LVL_W-1:0]  lowest_priority_q, lowest_priority_d;
  logic [PIC_LVL_W-1:0]  base, req_lvl, isr_lvl;
  logic [PIC_NUM_IR-1:0] req, eff_isr, req_rot, isr_rot, req_pick, isr_pick, grant, cleared;
  logic                  grant_ok;
  assign base    = lowest_priority_q + lvl_t'(1);
  assign req     = irr & ~imr;
  assign eff_isr = special_mask_mode ? (in_service_q & ~imr) : in_service_q;
  assign req_rot = rotate_right(req, base);
  assign isr_rot = rotate_right(eff_isr, base);
  pic_priority_resolver u_req (.vec(req_rot), .pick(req_pick));
  pic_priority_resolver u_isr (.vec(isr_rot), .pick(isr_pick));
  // In the rotated domain a smaller index means higher priority.
  assign req_lvl  = onehot_to_level(req_pick);
  assign isr_lvl  = onehot_to_level(isr_pick);
  assign grant_ok = |req_pick && (!(|isr_pick) || req_lvl < isr_lvl || (req_lvl == isr_lvl && special_fully_nested));
  assign grant    = grant_ok ? rotate_left(req_pick, base) : '0;
  assign cleared  = end_of_interrupt & in_service_q;
  always_comb begin
    interrupt_d       = freeze ? interrupt_q : grant;
    in_service_d      = (in_service_q & ~end_of_interrupt) | (latch_in_service ? interrupt_q : '0);
    lowest_priority_d = priority_rotate_set ? priority_rotate_level
                      : (rotate_on_eoi && |cleared) ? top_level(cleared, lowest_priority_q)
                      : (auto_rotate && latch_in_service && |interrupt_q) ? onehot_to_level(interrupt_q)
                      : lowest_priority_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interrupt_q       <= '0;
      in_service_q      <= '0;
      lowest_priority_q <= lvl_t'(PIC_NUM_IR - 1);
    end else begin
      interrupt_q       <= interrupt_d;
      in_service_q      <= in_service_d;
      lowest_priority_q <= lowest_priority_d;
    end
  end
  assign interrupt          = interrupt_q;
  assign in_service         = in_service_q;
  assign lowest_priority    = lowest_priority_q;
  assign highest_in_service = top_level(in_service_q, lowest_priority_q);
  assign isr_active         = |in_service_q;
endmodule

// File: tb/tb_pic_priority_isr.sv
// tb_pic_priority_isr: directed plan scenarios plus randomized run against a rank-based model
module tb_pic_priority_isr;
  logic clk = 0, rst = 1;
  logic [7:0] irr = 0, imr = 0, eoi = 0;
  logic smm = 0, sfnm = 0, ar = 0, lat = 0, frz = 0, roe = 0, prs = 0;
  logic [2:0] prl = 0;
  logic [7:0] interrupt, in_service;
  logic [2:0] his, lp;
  logic active;
  int passed = 0, total = 0;
  logic [7:0] m_int = 0, m_isr = 0;
  logic [2:0] m_ptr = 7;

  pic_priority_isr dut (
    .clk(clk), .rst(rst), .irr(irr), .imr(imr), .special_mask_mode(smm),
    .special_fully_nested(sfnm), .auto_rotate(ar), .latch_in_service(lat), .freeze(frz),
    .end_of_interrupt(eoi), .rotate_on_eoi(roe), .priority_rotate_set(prs),
    .priority_rotate_level(prl), .interrupt(interrupt), .in_service(in_service),
    .highest_in_service(his), .isr_active(active), .lowest_priority(lp)
  );

  always #5 clk = ~clk;

  // Rank 0 is the highest priority: the level just above the lowest-priority pointer.
  function automatic int rank(int lvl, int ptr);
    return (lvl - ptr - 1 + 16) % 8;
  endfunction

  function automatic logic [2:0] top_lvl(logic [7:0] v, int ptr);
    for (int k = 0; k < 8; k++) if (v[(ptr + 1 + k) % 8]) return 3'((ptr + 1 + k) % 8);
    return 3'd0;
  endfunction

  function automatic logic [7:0] m_grant(logic [7:0] r, logic [7:0] m, logic [7:0] isr, int ptr, logic sm, logic sf);
    logic [7:0] req, eff;
    int rr, re;
    req = r & ~m;
    eff = sm ? (isr & ~m) : isr;
    rr = 8;
    re = 8;
    for (int l = 0; l < 8; l++) begin
      if (req[l] && rank(l, ptr) < rr) rr = rank(l, ptr);
      if (eff[l] && rank(l, ptr) < re) re = rank(l, ptr);
    end
    if (rr == 8) return 8'h00;
    if (rr < re || (rr == re && sf)) return 8'h01 << ((ptr + 1 + rr) % 8);
    return 8'h00;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_int <= 0;
      m_isr <= 0;
      m_ptr <= 7;
    end else begin
      m_int <= frz ? m_int : m_grant(irr, imr, m_isr, int'(m_ptr), smm, sfnm);
      m_isr <= (m_isr & ~eoi) | (lat ? m_int : 8'h00);
      if (prs) m_ptr <= prl;
      else if (roe && (eoi & m_isr) != 0) m_ptr <= top_lvl(eoi & m_isr, int'(m_ptr));
      else if (ar && lat && m_int != 0) m_ptr <= top_lvl(m_int, int'(m_ptr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #2;
    total++; if (interrupt !== 8'h00) $display("FAIL reset_int got %h want 00", interrupt); else passed++;
    total++; if (in_service !== 8'h00) $display("FAIL reset_isr got %h want 00", in_service); else passed++;
    total++; if (lp !== 3'd7) $display("FAIL reset_ptr got %0d want 7", lp); else passed++;
    total++; if (his !== 3'd0 || active !== 1'b0) $display("FAIL reset_his got %0d/%b want 0/0", his, active); else passed++;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_basic_grant();
    irr = 8'h12; tick();
    total++; if (interrupt !== 8'h02) $display("FAIL basic_int got %h want 02", interrupt); else passed++;
    total++; if (lp !== 3'd7) $display("FAIL basic_ptr got %0d want 7", lp); else passed++;
  endtask

  task automatic test_nesting();
    lat = 1; tick(); lat = 0;
    total++; if (in_service !== 8'h02) $display("FAIL nest_isr got %h want 02", in_service); else passed++;
    total++; if (his !== 3'd1 || active !== 1'b1) $display("FAIL nest_his got %0d/%b want 1/1", his, active); else passed++;
    irr = 8'h10; tick();
    total++; if (interrupt !== 8'h00) $display("FAIL nest_blocked got %h want 00", interrupt); else passed++;
    irr = 8'h11; tick();
    total++; if (interrupt !== 8'h01) $display("FAIL nest_preempt got %h want 01", interrupt); else passed++;
  endtask

  task automatic test_sfnm_smm();
    irr = 8'h02; sfnm = 0; tick();
    total++; if (interrupt !== 8'h00) $display("FAIL sfnm0 got %h want 00", interrupt); else passed++;
    sfnm = 1; tick();
    total++; if (interrupt !== 8'h02) $display("FAIL sfnm1 got %h want 02", interrupt); else passed++;
    sfnm = 0; smm = 1; imr = 8'h02; irr = 8'h08; tick();
    total++; if (interrupt !== 8'h08) $display("FAIL smm got %h want 08", interrupt); else passed++;
    smm = 0; imr = 0;
  endtask

  task automatic test_rotation();
    irr = 8'h00; eoi = 8'h02; tick(); eoi = 0;
    total++; if (in_service !== 8'h00) $display("FAIL rot_clear got %h want 00", in_service); else passed++;
    irr = 8'h11; prs = 1; prl = 3; tick(); prs = 0;
    total++; if (lp !== 3'd3) $display("FAIL rot_set got %0d want 3", lp); else passed++;
    tick();
    total++; if (interrupt !== 8'h10) $display("FAIL rot_int got %h want 10", interrupt); else passed++;
    lat = 1; tick(); lat = 0;
    total++; if (in_service !== 8'h10) $display("FAIL rot_latch got %h want 10", in_service); else passed++;
    eoi = 8'h10; roe = 1; tick(); eoi = 0; roe = 0;
    total++; if (in_service !== 8'h00 || lp !== 3'd4) $display("FAIL rot_eoi got %h/%0d want 00/4", in_service, lp); else passed++;
  endtask

  task automatic test_freeze();
    irr = 8'h02; tick();
    total++; if (interrupt !== 8'h02) $display("FAIL frz_pre got %h want 02", interrupt); else passed++;
    frz = 1; irr = 8'h01; tick(); tick();
    total++; if (interrupt !== 8'h02) $display("FAIL frz_hold got %h want 02", interrupt); else passed++;
    frz = 0; tick();
    total++; if (interrupt !== 8'h01) $display("FAIL frz_release got %h want 01", interrupt); else passed++;
  endtask

  task automatic test_async_reset();
    irr = 8'h01; prs = 1; prl = 2; tick(); prs = 0;
    lat = 1; tick(); lat = 0;
    smm = 1; imr = 8'h01; irr = 8'h04; tick();
    lat = 1; tick(); lat = 0;
    total++; if (in_service !== 8'h05 || lp !== 3'd2) $display("FAIL arst_pre got %h/%0d want 05/2", in_service, lp); else passed++;
    #2 rst = 1;
    #1;
    total++; if (in_service !== 8'h00 || interrupt !== 8'h00 || lp !== 3'd7) $display("FAIL arst got %h/%h/%0d want 00/00/7", in_service, interrupt, lp); else passed++;
    smm = 0; imr = 0; irr = 0;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      irr  = 8'($urandom);
      imr  = 8'($urandom & $urandom & $urandom);
      eoi  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      smm  = ($urandom_range(0, 3) == 0);
      sfnm = ($urandom_range(0, 3) == 0);
      ar   = ($urandom_range(0, 3) == 0);
      lat  = ($urandom_range(0, 2) == 0);
      frz  = ($urandom_range(0, 7) == 0);
      roe  = ($urandom_range(0, 3) == 0);
      prs  = ($urandom_range(0, 15) == 0);
      prl  = 3'($urandom);
      tick();
      total++; if (interrupt !== m_int) $display("FAIL rnd_int[%0d] got %h want %h", n, interrupt, m_int); else passed++;
      total++; if (in_service !== m_isr) $display("FAIL rnd_isr[%0d] got %h want %h", n, in_service, m_isr); else passed++;
      total++; if (lp !== m_ptr) $display("FAIL rnd_ptr[%0d] got %0d want %0d", n, lp, m_ptr); else passed++;
      total++; if (his !== top_lvl(m_isr, int'(m_ptr)) || active !== (m_isr != 0)) $display("FAIL rnd_his[%0d] got %0d/%b want %0d/%b", n, his, active, top_lvl(m_isr, int'(m_ptr)), m_isr != 0); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic_grant();
    test_nesting();
    test_sfnm_smm();
    test_rotation();
    test_freeze();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pic_priority_isr.md
Name: pic_priority_isr

Overview:
Priority resolver plus In-Service Register (ISR) stage of the 8259-compatible PIC. It sits directly upstream of PIC_controlLogic and drives that block's INTERRUPT input with a one-hot request vector. It consumes from the control logic:
- LATCH, which sets ISR bits on the first ACK.
- FREEZE, which holds the output during the ACK sequence.
- The one-hot EOI vector, which clears ISR bits.
It implements fully nested, special fully nested (SFNM), special mask (SMM) and rotating priority.

Parameters:
- NUM_IR, 8, number of interrupt lines. Fixed at 8; the level width is 3.
- LVL_W, 3, width of level/pointer fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- irr  in  8  interrupt request register contents, already edge/level qualified.
- imr  in  8  interrupt mask register; 1 = masked.
- special_mask_mode  in  1  SMM (OCW3).
- special_fully_nested  in  1  SFNM (ICW4, cascade master).
- auto_rotate  in  1  rotate on AEOI.
- latch_in_service  in  1  LATCH pulse from control logic.
- freeze  in  1  FREEZE from control logic; holds `interrupt`.
- end_of_interrupt  in  8  EOI bit vector from control logic; 1 = clear that ISR bit.
- rotate_on_eoi  in  1  rotate when an EOI clears a bit.
- priority_rotate_set  in  1  specific rotate strobe (OCW2 set-priority).
- priority_rotate_level  in  3  level to become lowest priority.
- interrupt  out  8  one-hot granted request, to PIC_controlLogic INTERRUPT.
- in_service  out  8  ISR contents.
- highest_in_service  out  3  level of highest-priority ISR bit.
- isr_active  out  1  `in_service` is non-zero.
- lowest_priority  out  3  current priority pointer.

Behaviour:
- Reset is asynchronous, active-high. While `rst` is high and afterwards:
  - interrupt = 0, in_service = 0, lowest_priority = 3'd7 (IR0 highest, IR7 lowest).
  - highest_in_service = 0, isr_active = 0.
  - Reset asserted mid-sequence clears everything on that edge, with no partial state.
- Priority order: highest priority is level (lowest_priority+1) mod 8, ascending with wrap-around.
- Candidate requests: req = irr & ~imr.
- Blocking vector:
  - eff_isr = in_service, or in_service & ~imr when special_mask_mode = 1.
- Grant rule: take the highest-priority bit of req. It is granted only if:
  - eff_isr is empty, or
  - its priority is strictly higher than the highest bit of eff_isr, or
  - its priority is equal to it and special_fully_nested = 1.
- `interrupt` is registered.
  - Each clock with freeze = 0: interrupt <= granted one-hot, or 0 if nothing is granted.
  - With freeze = 1: interrupt holds.
  - Latency is 1 clock from irr/imr/ISR/pointer change to `interrupt`.
- ISR update each clock, in this order:
  - in_service <= (in_service & ~end_of_interrupt) | (latch_in_service ? interrupt : 0).
  - If a set and a clear hit the same bit in the same cycle, the set wins.
  - latch_in_service with interrupt = 0 leaves the ISR unchanged.
- Pointer update, priority high to low:
  1. priority_rotate_set: lowest_priority <= priority_rotate_level.
  2. rotate_on_eoi with (end_of_interrupt & in_service) non-zero: lowest_priority <= level of the highest-priority bit among those cleared.
  3. auto_rotate & latch_in_service & interrupt non-zero: lowest_priority <= level being latched.
  4. Otherwise the pointer holds.
- EOI bits on inactive ISR bits are harmless: no clear and no rotate.
- highest_in_service and isr_active are combinational from the registered in_service and lowest_priority; glitch-free relative to clk.
- All state lives in a single always block with async reset. No latches.

Decomposition:
- Package pic_pkg holds:
  - constants PIC_NUM_IR = 8 and PIC_LVL_W = 3;
  - function rotate_right(vec, amt) and function rotate_left(vec, amt);
  - function onehot_to_level(vec) returning 3 bits.
- One sub-module, pic_priority_resolver. It is a combinational, lowest-index-first one-hot pick on a pre-rotated 8-bit vector.
- It is instantiated twice: once on req and once on eff_isr.
- Rotation happens in the parent using the package functions.

Test Plan:
1. Reset, then irr=8'h12, imr=0 -> after 1 clk interrupt=8'h02, lowest_priority=7.
2. latch_in_service pulse -> in_service=8'h02, highest_in_service=1. Then irr=8'h10 -> interrupt=0 (blocked); irr=8'h11 -> interrupt=8'h01.
3. With in_service=8'h02 and irr=8'h02:
   - SFNM=0 -> interrupt=0;
   - SFNM=1 -> interrupt=8'h02.
   - Then SMM=1 with imr=8'h02, irr=8'h08 -> interrupt=8'h08.
4. Rotation and EOI:
   - priority_rotate_set, level=3, irr=8'h11 -> interrupt=8'h10.
   - Latch it, then end_of_interrupt=8'h10 with rotate_on_eoi=1 -> in_service=0, lowest_priority=4.
5. Freeze: interrupt=8'h02, freeze=1, irr->8'h01 -> interrupt stays 8'h02. freeze=0 -> 8'h01 next clk.
6. Async reset mid-operation: assert rst between clk edges with in_service=8'h05 and pointer=2 -> immediately in_service=0, interrupt=0, lowest_priority=7.
